// File: rtl/mips_alu_pkg.sv
// Purpose: op codes, FSM state type and op classification for the EX-stage ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;
  localparam logic [3:0] OP_MTHI  = 4'b1110;
  localparam logic [3:0] OP_MTLO  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_RUN  = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_SIGN_FIX = 2'd3
  } state_e;

  // Multi-cycle ops occupy codes 1000..1011.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/mips_muldiv_core.sv
// Purpose: iterative shift-add multiplier / restoring divider on operand magnitudes, with sign fix.
// Latency: WIDTH iteration cycles after start; hi_out/lo_out are valid once the iterations are done.
// Backpressure: none; start restarts the engine, callers must not start while it is running.
module mips_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  import mips_alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_d, neg_acc;
  logic [WIDTH-1:0]   opnd_q, a_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q, neg_q, rneg_q, div0_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, addend;
  logic [WIDTH:0]     mul_sum, div_sh, div_diff;

  assign a_neg   = signed_op & a[WIDTH-1];
  assign b_neg   = signed_op & b[WIDTH-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign neg_acc = -acc_q;

  // Asserted during the final iteration so the caller can move to sign fix on the same edge.
  assign done = (cnt_q == CNT_W'(WIDTH - 1));

  // One iteration: multiply adds the multiplicand into the upper half and shifts right;
  // divide shifts {rem,quot} left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    addend   = acc_q[0] ? opnd_q : '0;
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Capture magnitudes and signs at start, then iterate until the counter reaches WIDTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= CNT_W'(WIDTH);
      acc_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else if (start) begin
      cnt_q    <= '0;
      is_div_q <= is_div;
      a_q      <= a;
      div0_q   <= is_div && (b == '0);
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      if (is_div) begin
        acc_q  <= {{WIDTH{1'b0}}, a_mag};
        opnd_q <= b_mag;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, b_mag};
        opnd_q <= a_mag;
      end
    end else if (cnt_q != CNT_W'(WIDTH)) begin
      cnt_q <= cnt_q + CNT_W'(1);
      acc_q <= acc_d;
    end
  end

  // Sign fix: divide-by-zero returns {dividend, all ones}; MIN/-1 falls out of the magnitude path.
  always_comb begin
    hi_out = acc_q[2*WIDTH-1:WIDTH];
    lo_out = acc_q[WIDTH-1:0];
    if (div0_q) begin
      hi_out = a_q;
      lo_out = '1;
    end else if (is_div_q) begin
      if (neg_q)  lo_out = -acc_q[WIDTH-1:0];
      if (rneg_q) hi_out = -acc_q[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      {hi_out, lo_out} = neg_acc;
    end
  end

endmodule

// File: rtl/mips_muldiv_alu.sv
// Purpose: registered EX-stage ALU with flags, HI/LO registers and an iterative mul/div engine.
// Latency: 1 cycle for single-cycle ops; WIDTH+2 cycles from accept to out_valid for mul/div.
// Backpressure: in_ready low while mul/div runs; outputs cannot be stalled (out_valid is a pulse).
module mips_muldiv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             c_out,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mips_alu_pkg::*;

  state_e           state_q;
  logic             in_ready_q, out_valid_q, zero_q, c_out_q, overflow_q;
  logic [WIDTH-1:0] result_q, hi_q, lo_q;

  logic             accept, core_start, core_done;
  logic [WIDTH-1:0] core_hi, core_lo, alu_res;
  logic             alu_c, alu_ov;
  logic [WIDTH:0]   add_full, sub_full;

  assign accept     = in_valid && in_ready_q && (state_q == ST_IDLE);
  assign core_start = accept && is_muldiv(alu_op);

  assign add_full = {1'b0, src_a} + {1'b0, src_b};
  assign sub_full = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};

  mips_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (core_start),
    .signed_op (~alu_op[0]),
    .is_div    (alu_op[1]),
    .a         (src_a),
    .b         (src_b),
    .done      (core_done),
    .hi_out    (core_hi),
    .lo_out    (core_lo)
  );

  // Single-cycle datapath: result and ADD/SUB carry and signed-overflow flags.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_ov  = 1'b0;
    case (alu_op)
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_ov  = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_full[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_ov  = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_full[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SLT:  alu_res = WIDTH'($signed(src_a) < $signed(src_b));
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_MTHI: alu_res = src_a;
      OP_MTLO: alu_res = src_a;
      default: alu_res = '0;
    endcase
  end

  // Control FSM with registered handshake, result, flags and HI/LO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      c_out_q     <= 1'b0;
      overflow_q  <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (is_muldiv(alu_op)) begin
              state_q    <= alu_op[1] ? ST_DIV_RUN : ST_MUL_RUN;
              in_ready_q <= 1'b0;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              c_out_q     <= alu_c;
              overflow_q  <= alu_ov;
              if (alu_op == OP_MTHI) hi_q <= src_a;
              if (alu_op == OP_MTLO) lo_q <= src_a;
            end
          end
        end
        ST_MUL_RUN, ST_DIV_RUN: begin
          if (core_done) state_q <= ST_SIGN_FIX;
        end
        ST_SIGN_FIX: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b1;
          hi_q        <= core_hi;
          lo_q        <= core_lo;
          result_q    <= core_lo;
          zero_q      <= (core_lo == '0);
          c_out_q     <= 1'b0;
          overflow_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mips_muldiv_alu.sv
// Purpose: directed self-checking bench for mips_muldiv_alu with hand-computed vectors.
// Latency: checks 1-cycle and WIDTH+2-cycle result timing.
// Backpressure: exercises busy in_ready and held in_valid across a mul.
module tb_mips_muldiv_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] src_a, src_b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero, c_out, overflow;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_muldiv_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .c_out     (c_out),
    .overflow  (overflow),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns #1 after the accept edge with operands scrambled.
  task automatic accept_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    alu_op = op; src_a = a; src_b = b; in_valid = 1'b1;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("accept wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src_a = $urandom();
    src_b = $urandom();
  endtask

  task automatic run_single(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_z, input logic exp_c,
                            input logic exp_ov, input string tag);
    accept_op(op, a, b);
    @(negedge clk);
    chk({tag, " valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " zero"}, {31'd0, zero}, {31'd0, exp_z});
    chk({tag, " c_out"}, {31'd0, c_out}, {31'd0, exp_c});
    chk({tag, " ovf"}, {31'd0, overflow}, {31'd0, exp_ov});
    chk({tag, " ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int n, low;
    n = 0; low = 0;
    accept_op(op, a, b);
    do begin
      @(negedge clk);
      n++;
      if (!in_ready) low++;
    end while (!out_valid && n < 100);
    chk({tag, " latency"}, n, 32'd34);
    chk({tag, " busy cycles"}, low, 32'd33);
    chk({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    chk({tag, " result"}, result, exp_lo);
    chk({tag, " zero"}, {31'd0, zero}, {31'd0, (exp_lo == 32'd0)});
    @(negedge clk);
    chk({tag, " pulse"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int n, seen;
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 4'd0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    chk("rst in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst zero", {31'd0, zero}, 32'd1);
    chk("rst result", result, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst release ready", {31'd0, in_ready}, 32'd1);

    // Single-cycle ops: a op b -> result, zero, c_out, overflow
    run_single(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, "add ovf");
    run_single(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, "add carry");
    run_single(4'b0110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b1, 1'b0, "sub eq");
    run_single(4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, "sub ovf");
    run_single(4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "sub borrow");
    run_single(4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, "slt neg");
    run_single(4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0, "slt pos");
    run_single(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, "and");
    run_single(4'b0001, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1'b0, 1'b0, 1'b0, "or");
    run_single(4'b0011, 32'd5, 32'd6, 32'd0, 1'b1, 1'b0, 1'b0, "unused op");

    // Multiply / divide
    run_md(4'b1000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult");
    run_md(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu");
    run_single(4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, "mfhi");
    run_md(4'b1010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
    run_md(4'b1011, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, "divu by0");
    run_md(4'b1011, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
    run_md(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div min");

    // Reset during a running MULT aborts it and clears HI/LO.
    @(negedge clk);
    accept_op(4'b1000, 32'd6, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort ready", {31'd0, in_ready}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort zero", {31'd0, zero}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort ready back", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no valid", seen, 32'd0);

    // in_valid held: MULT then ADD; ADD only lands once the MULT completes.
    alu_op = 4'b1000; src_a = 32'hFFFF_FFFD; src_b = 32'd5; in_valid = 1'b1;
    @(posedge clk);
    #1;
    alu_op = 4'b0010; src_a = 32'd2; src_b = 32'd3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    chk("b2b mult latency", n, 32'd34);
    chk("b2b mult result", result, 32'hFFFF_FFF1);
    chk("b2b ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b add valid", {31'd0, out_valid}, 32'd1);
    chk("b2b add result", result, 32'd5);
    chk("b2b hi kept", hi, 32'hFFFF_FFFF);

    run_single(4'b1111, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, "mtlo");
    chk("mtlo lo", lo, 32'h0000_1234);
    chk("mtlo hi kept", hi, 32'hFFFF_FFFF);
    run_single(4'b1101, 32'd0, 32'd0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, "mflo");
    run_single(4'b1110, 32'hCAFE_0000, 32'd0, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, "mthi");
    chk("mthi hi", hi, 32'hCAFE_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
